// File: rtl/mac_accumulator.sv
// mac_accumulator: feeds operand pairs to the external 8x8 shift-add
// multiplier one at a time, waits for its (edge-qualified) done indication,
// and sums the products into a wide unsigned accumulator. When the term
// tagged "last" has been accumulated, the sum, term count and overflow flag
// are published on the res_* outputs with a one-cycle res_valid pulse.
// A multiply that never completes is abandoned after TIMEOUT_CYC wait
// cycles and flagged on the sticky timeout_err output.

module mac_accumulator #(
    parameter int ACC_W       = 24,   // accumulator/result width, >= 16
    parameter bit SATURATE    = 1'b1, // 1: clamp on overflow, 0: wrap
    parameter int TIMEOUT_CYC = 64    // wait cycles before a multiply is hung
) (
    input  logic             clk,
    input  logic             reset,

    // operand stream
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    input  logic             clear_acc,

    // multiplier interface
    output logic [7:0]       a_in,
    output logic [7:0]       b_in,
    output logic             Begin_mul,
    input  logic [15:0]      mult_out,
    input  logic             End_mul,

    // result interface
    output logic             res_valid,
    output logic [ACC_W-1:0] res_acc,
    output logic [7:0]       res_count,
    output logic             res_ovf,

    // status
    output logic             busy,
    output logic             timeout_err
);

    // Hang counter only needs to reach TIMEOUT_CYC-1 before we give up.
    localparam int                HANG_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(TIMEOUT_CYC - 1);
    localparam logic [ACC_W-1:0]  ACC_ONES  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACCUM = 2'd3
    } state_t;

    state_t state_q, state_d;

    // datapath registers
    logic [ACC_W-1:0]  acc_q,       acc_d;
    logic [7:0]        count_q,     count_d;
    logic              ovf_q,       ovf_d;
    logic [7:0]        a_q,         a_d;
    logic [7:0]        b_q,         b_d;
    logic              last_q,      last_d;
    logic [15:0]       prod_q,      prod_d;
    logic [HANG_W-1:0] hang_q,      hang_d;
    logic              seen_low_q,  seen_low_d;
    logic              res_valid_q, res_valid_d;
    logic [ACC_W-1:0]  res_acc_q,   res_acc_d;
    logic [7:0]        res_count_q, res_count_d;
    logic              res_ovf_q,   res_ovf_d;
    logic              timeout_q,   timeout_d;

    // decoded events
    logic              accept;
    logic              capture;
    logic              hang_expire;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_new;
    logic [7:0]        count_new;
    logic              ovf_new;

    // A pair is taken whenever we sit in IDLE and the source offers one.
    assign accept = (state_q == ST_IDLE) && in_valid;

    // End_mul only counts once it has been seen low during this WAIT, so a
    // level left high from the previous multiply cannot be mistaken for done.
    assign capture = (state_q == ST_WAIT) && End_mul && seen_low_q;

    // A real completion on the last allowed cycle wins over the timeout.
    assign hang_expire = (state_q == ST_WAIT) && !capture && (hang_q == HANG_LAST);

    // One extra bit of headroom exposes the carry out of the accumulator.
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod_q};

    // Overflow handling and saturating term count for the ACCUM step.
    always_comb begin
        acc_new   = sum[ACC_W-1:0];
        ovf_new   = ovf_q;
        if (sum[ACC_W]) begin
            ovf_new = 1'b1;
            if (SATURATE) begin
                acc_new = ACC_ONES;
            end
        end
        count_new = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one term in flight, start -> wait -> accumulate.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture) begin
                    state_d = ST_ACCUM;
                end else if (hang_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs: handshake, start pulse and busy flag.
    always_comb begin
        in_ready  = 1'b0;
        Begin_mul = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_START: begin
                Begin_mul = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
            end
        endcase
    end

    // Datapath next-state: operand latch, wait bookkeeping, accumulation.
    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        a_d         = a_q;
        b_d         = b_q;
        last_d      = last_q;
        prod_d      = prod_q;
        hang_d      = hang_q;
        seen_low_d  = seen_low_q;
        res_valid_d = 1'b0;
        res_acc_d   = res_acc_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;
        timeout_d   = timeout_q;

        case (state_q)
            ST_IDLE: begin
                // Clear first so a term accepted in the same cycle adds to 0.
                if (clear_acc) begin
                    acc_d   = '0;
                    count_d = 8'd0;
                    ovf_d   = 1'b0;
                end
                if (accept) begin
                    a_d    = in_a;
                    b_d    = in_b;
                    last_d = in_last;
                end
            end

            ST_START: begin
                hang_d     = '0;
                seen_low_d = 1'b0;
            end

            ST_WAIT: begin
                hang_d = hang_q + 1'b1;
                if (!End_mul) begin
                    seen_low_d = 1'b1;
                end
                if (capture) begin
                    prod_d = mult_out;
                end
                // Term is dropped: accumulator state is left untouched.
                if (hang_expire) begin
                    timeout_d = 1'b1;
                end
            end

            ST_ACCUM: begin
                if (last_q) begin
                    res_acc_d   = acc_new;
                    res_count_d = count_new;
                    res_ovf_d   = ovf_new;
                    res_valid_d = 1'b1;
                    acc_d       = '0;
                    count_d     = 8'd0;
                    ovf_d       = 1'b0;
                end else begin
                    acc_d       = acc_new;
                    count_d     = count_new;
                    ovf_d       = ovf_new;
                end
            end

            default: begin
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset clears everything including the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            count_q     <= 8'd0;
            ovf_q       <= 1'b0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            last_q      <= 1'b0;
            prod_q      <= 16'd0;
            hang_q      <= '0;
            seen_low_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_acc_q   <= '0;
            res_count_q <= 8'd0;
            res_ovf_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            a_q         <= a_d;
            b_q         <= b_d;
            last_q      <= last_d;
            prod_q      <= prod_d;
            hang_q      <= hang_d;
            seen_low_q  <= seen_low_d;
            res_valid_q <= res_valid_d;
            res_acc_q   <= res_acc_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
            timeout_q   <= timeout_d;
        end
    end

    assign a_in        = a_q;
    assign b_in        = b_q;
    assign res_valid   = res_valid_q;
    assign res_acc     = res_acc_q;
    assign res_count   = res_count_q;
    assign res_ovf     = res_ovf_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: two mac_accumulator instances (ACC_W=16, one
// saturating, one wrapping) driven in lockstep. The bench plays the role of
// the multiplier. Expected results come from a plain-arithmetic model of the
// running dot product and are queued when issued; a monitor pops and
// compares whenever a DUT pulses res_valid.

module tb_mac_accumulator;

    localparam int     W    = 16;
    localparam int     TO   = 64;
    localparam longint AMAX = (longint'(1) << W) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_last, clear_acc, End_mul;
    logic [7:0]    in_a, in_b;
    logic [15:0]   mult_out;

    logic          s_in_ready, s_Begin_mul, s_res_valid, s_res_ovf, s_busy, s_timeout_err;
    logic [7:0]    s_a_in, s_b_in, s_res_count;
    logic [W-1:0]  s_res_acc;
    logic          w_in_ready, w_Begin_mul, w_res_valid, w_res_ovf, w_busy, w_timeout_err;
    logic [7:0]    w_a_in, w_b_in, w_res_count;
    logic [W-1:0]  w_res_acc;

    mac_accumulator #(.ACC_W(W), .SATURATE(1'b1), .TIMEOUT_CYC(TO)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .clear_acc(clear_acc),
        .a_in(s_a_in), .b_in(s_b_in), .Begin_mul(s_Begin_mul),
        .mult_out(mult_out), .End_mul(End_mul),
        .res_valid(s_res_valid), .res_acc(s_res_acc), .res_count(s_res_count),
        .res_ovf(s_res_ovf), .busy(s_busy), .timeout_err(s_timeout_err)
    );

    mac_accumulator #(.ACC_W(W), .SATURATE(1'b0), .TIMEOUT_CYC(TO)) dut_wrap (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .clear_acc(clear_acc),
        .a_in(w_a_in), .b_in(w_b_in), .Begin_mul(w_Begin_mul),
        .mult_out(mult_out), .End_mul(End_mul),
        .res_valid(w_res_valid), .res_acc(w_res_acc), .res_count(w_res_count),
        .res_ovf(w_res_ovf), .busy(w_busy), .timeout_err(w_timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        int     cnt;
        bit     ovf;
    } exp_t;

    exp_t   q_sat[$];
    exp_t   q_wrap[$];
    int     total = 0;
    int     bad   = 0;

    // reference model: true (unbounded) running sum and number of terms
    longint m_sum  = 0;
    int     m_n    = 0;
    longint hold_s = 0;
    longint hold_w = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Account for one completed multiply; publish the expected result on last.
    task automatic model_add(input logic [7:0] a, input logic [7:0] b, input bit last);
        exp_t es, ew;
        m_sum += longint'(a) * longint'(b);
        m_n++;
        if (last) begin
            es.acc = (m_sum > AMAX) ? AMAX : m_sum;
            ew.acc = m_sum % (AMAX + 1);
            es.cnt = (m_n > 255) ? 255 : m_n;
            ew.cnt = es.cnt;
            es.ovf = (m_sum > AMAX);
            ew.ovf = es.ovf;
            q_sat.push_back(es);
            q_wrap.push_back(ew);
            hold_s = es.acc;
            hold_w = ew.acc;
            m_sum  = 0;
            m_n    = 0;
        end
    endtask

    // Monitor: compares every res_valid pulse against the head of its queue.
    bit   prev_s = 1'b0;
    bit   prev_w = 1'b0;
    exp_t e_s, e_w;
    always @(negedge clk) begin
        if (reset) begin
            prev_s = 1'b0;
            prev_w = 1'b0;
        end else begin
            if (s_res_valid) begin
                check("sat_res_valid_width", prev_s, 0);
                check("sat_res_pending", q_sat.size(), 1);
                if (q_sat.size() > 0) begin
                    e_s = q_sat.pop_front();
                    $display("sat  result: acc=%0d cnt=%0d ovf=%0d (exp %0d/%0d/%0d)",
                             s_res_acc, s_res_count, s_res_ovf, e_s.acc, e_s.cnt, e_s.ovf);
                    check("sat_res_acc", s_res_acc, e_s.acc);
                    check("sat_res_count", s_res_count, e_s.cnt);
                    check("sat_res_ovf", s_res_ovf, e_s.ovf);
                end
            end
            if (w_res_valid) begin
                check("wrap_res_valid_width", prev_w, 0);
                check("wrap_res_pending", q_wrap.size(), 1);
                if (q_wrap.size() > 0) begin
                    e_w = q_wrap.pop_front();
                    $display("wrap result: acc=%0d cnt=%0d ovf=%0d (exp %0d/%0d/%0d)",
                             w_res_acc, w_res_count, w_res_ovf, e_w.acc, e_w.cnt, e_w.ovf);
                    check("wrap_res_acc", w_res_acc, e_w.acc);
                    check("wrap_res_count", w_res_count, e_w.cnt);
                    check("wrap_res_ovf", w_res_ovf, e_w.ovf);
                end
            end
            prev_s = s_res_valid;
            prev_w = w_res_valid;
        end
    end

    // Offer a pair, then step through START into the first WAIT cycle.
    // With stale=1, End_mul is already high (with a bogus product) at accept.
    task automatic start_term(input logic [7:0] a, input logic [7:0] b,
                              input bit last, input bit clr, input bit stale);
        int k = 0;
        while (!s_in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_in_ready", s_in_ready, 1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_last   = last;
        clear_acc = clr;
        if (clr) begin
            m_sum = 0;
            m_n   = 0;
        end
        End_mul  = stale;
        mult_out = stale ? 16'hBEEF : 16'h0000;
        @(negedge clk);
        in_valid  = 1'b0;
        clear_acc = 1'b0;
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        in_last   = 1'($urandom);
        check("start_begin_mul", s_Begin_mul, 1);
        check("start_begin_mul_wrap", w_Begin_mul, 1);
        check("start_in_ready_low", s_in_ready, 0);
        check("start_a_in", s_a_in, a);
        check("start_b_in", s_b_in, b);
        @(negedge clk);
        check("wait_begin_mul_low", s_Begin_mul, 0);
        check("wait_busy_first", s_busy, 1);
    endtask

    // Complete the multiply after lat cycles (counted from Begin_mul).
    task automatic finish_term(input logic [7:0] a, input logic [7:0] b,
                               input bit last, input int lat, input bit stale);
        int hold;
        int l;
        l = (stale && lat < 6) ? 6 : lat;
        for (int i = 1; i < l; i++) begin
            End_mul   = stale && (i <= 3);
            clear_acc = ($urandom_range(0, 7) == 0);  // must be ignored here
            check("wait_busy", s_busy, 1);
            @(negedge clk);
        end
        clear_acc = 1'b0;
        End_mul   = 1'b1;
        mult_out  = 16'(a * b);
        model_add(a, b, last);
        hold = $urandom_range(1, 2);
        @(negedge clk);
        check("accum_busy", s_busy, 1);
        check("accum_a_in_held", s_a_in, a);
        check("accum_b_in_held", s_b_in, b);
        if (hold == 1) End_mul = 1'b0;
        @(negedge clk);
        check("res_valid_latency_sat", s_res_valid, last);
        check("res_valid_latency_wrap", w_res_valid, last);
        check("idle_busy_low", s_busy, 0);
        check("idle_in_ready", s_in_ready, 1);
        End_mul  = 1'b0;
        mult_out = 16'($urandom);
        if (!last) begin
            check("res_acc_hold_sat", s_res_acc, hold_s);
            check("res_acc_hold_wrap", w_res_acc, hold_w);
        end
    endtask

    task automatic term(input logic [7:0] a, input logic [7:0] b, input bit last,
                        input bit clr, input bit stale, input int lat);
        start_term(a, b, last, clr, stale);
        finish_term(a, b, last, lat, stale);
    endtask

    // Never complete the multiply; expect exactly TO wait cycles then IDLE.
    task automatic timeout_term(input logic [7:0] a, input logic [7:0] b);
        int n = 1;
        start_term(a, b, 1'b0, 1'b0, 1'b0);
        End_mul = 1'b0;
        for (int k = 0; k < 100 && s_busy; k++) begin
            @(negedge clk);
            if (s_busy) n++;
        end
        check("timeout_wait_cycles", n, TO);
        check("timeout_err_sat", s_timeout_err, 1);
        check("timeout_err_wrap", w_timeout_err, 1);
        check("timeout_idle", s_busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        clear_acc = 1'b0;
        End_mul   = 1'b0;
        mult_out  = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", s_in_ready, 1);
        check("reset_busy", s_busy, 0);
        check("reset_begin_mul", s_Begin_mul, 0);
        check("reset_res_valid", s_res_valid, 0);
        check("reset_res_acc", s_res_acc, 0);
        check("reset_res_count", s_res_count, 0);
        check("reset_timeout_err", s_timeout_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // basic dot product: 3*4 + 5*6 = 42
        term(8'd3, 8'd4, 1'b0, 1'b0, 1'b0, 18);
        term(8'd5, 8'd6, 1'b1, 1'b0, 1'b0, 18);

        // overflow: saturate to 65535, wrap to 64514
        term(8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 4);
        term(8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 4);

        // stale End_mul level must not capture the bogus product
        term(8'd12, 8'd13, 1'b0, 1'b0, 1'b1, 8);
        term(8'd1, 8'd1, 1'b1, 1'b0, 1'b0, 3);

        // hung multiply is dropped; accumulation continues from prior value
        term(8'd20, 8'd30, 1'b0, 1'b0, 1'b0, 5);
        term(8'd4, 8'd5, 1'b0, 1'b0, 1'b0, 5);
        timeout_term(8'd9, 8'd9);
        term(8'd2, 8'd2, 1'b1, 1'b0, 1'b0, 5);
        check("timeout_err_sticky", s_timeout_err, 1);

        // clear together with acceptance
        term(8'd10, 8'd10, 1'b0, 1'b0, 1'b0, 3);
        term(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 3);

        // term count saturates at 255
        for (int i = 0; i < 260; i++) begin
            term(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 2);
        end
        term(8'd1, 8'd1, 1'b1, 1'b0, 1'b0, 2);

        // randomized terms
        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            term(ra, rb, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(2, 25));
        end
        term(8'd7, 8'd7, 1'b1, 1'b0, 1'b0, 2);

        // reset while waiting for the multiplier
        start_term(8'd7, 8'd9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", s_busy, 0);
        check("midreset_in_ready", s_in_ready, 1);
        check("midreset_res_valid", s_res_valid, 0);
        check("midreset_res_acc", s_res_acc, 0);
        check("midreset_res_count", s_res_count, 0);
        check("midreset_res_ovf", s_res_ovf, 0);
        check("midreset_timeout_err", s_timeout_err, 0);
        check("midreset_a_in", s_a_in, 0);
        reset  = 1'b0;
        m_sum  = 0;
        m_n    = 0;
        hold_s = 0;
        hold_w = 0;
        repeat (5) @(negedge clk);
        term(8'd3, 8'd3, 1'b1, 1'b0, 1'b0, 4);
        repeat (4) @(negedge clk);

        check("sat_queue_drained", q_sat.size(), 0);
        check("wrap_queue_drained", q_wrap.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequencing and accumulation stage wrapped around the 8x8 shift-add multiplier (top_multiplier).
- Accepts operand pairs over a valid/ready handshake and launches one multiply per pair using Begin_mul.
- Waits for End_mul, then adds mult_out into a wide unsigned accumulator.
- Emits the dot-product result when the term tagged `last` has been accumulated.

Parameters:
ACC_W, 24, accumulator and result width in bits; must be >= 16.
SATURATE, 1, 1 = clamp to all-ones on overflow; 0 = wrap modulo 2^ACC_W.
TIMEOUT_CYC, 64, WAIT cycles allowed before a multiply is declared hung; must be >= 20.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair on in_a/in_b/in_last is valid
in_ready  output  1  block can accept a pair this cycle
in_a  input  8  multiplicand
in_b  input  8  multiplier
in_last  input  1  this pair is the final term of the current accumulation
clear_acc  input  1  zero accumulator, term count and overflow; honoured only in IDLE
a_in  output  8  to multiplier a_in; held stable from START until ACCUM
b_in  output  8  to multiplier b_in; held stable from START until ACCUM
Begin_mul  output  1  one-cycle start pulse to multiplier
mult_out  input  16  product from multiplier
End_mul  input  1  multiplier done indication; may be a level or a pulse
res_valid  output  1  one-cycle pulse; res_acc/res_count/res_ovf are updated
res_acc  output  ACC_W  final accumulated sum
res_count  output  8  number of terms accumulated, saturating at 255
res_ovf  output  1  overflow occurred during this accumulation
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky; set on hang, cleared only by reset

Behaviour:
- Reset (synchronous, active-high): state=IDLE.
  - Accumulator, count, ovf, operand registers, res_acc, res_count, res_ovf all 0.
  - Begin_mul=0, res_valid=0, timeout_err=0, in_ready=1 in the first cycle after reset.
  - Reset mid-multiply abandons the term; the multiplier is reset by the same signal.
- States: IDLE, START, WAIT, ACCUM.
- IDLE:
  - in_ready=1.
  - If clear_acc is high, acc, count and ovf are zeroed.
  - On in_valid & in_ready: latch in_a, in_b, in_last, then go to START.
  - clear_acc and acceptance in the same cycle: clear takes effect first; the new term adds to 0.
- START:
  - Begin_mul=1 for exactly this cycle; in_ready=0.
  - Next state is WAIT; the hang counter and the seen_low flag are zeroed.
- WAIT:
  - End_mul is edge-qualified: seen_low is set when End_mul=0 is sampled.
  - The product is captured only when End_mul=1 and seen_low=1, so a stale level-high End_mul is ignored. Then go to ACCUM.
  - The hang counter increments each cycle. At TIMEOUT_CYC: set timeout_err, drop the term (acc unchanged), go to IDLE.
- ACCUM (one cycle):
  - Compute sum = acc + zero-extended product, ACC_W+1 bits wide.
  - If there is a carry:
    - SATURATE=1: acc = all ones.
    - SATURATE=0: acc = low ACC_W bits.
    - ovf set in either case.
  - Otherwise acc = sum.
  - count increments, saturating at 255.
  - If last:
    - res_acc/res_count/res_ovf take the updated values; res_valid pulses next cycle.
    - acc, count and ovf are zeroed.
  - Next state is IDLE.
- Latency and throughput:
  - Accept-to-Begin_mul: 1 cycle.
  - End_mul qualified-to-res_valid: 2 cycles.
  - One term in flight at a time; in_ready=0 from START through ACCUM.
- Result outputs hold their values until the next last term completes.
- clear_acc outside IDLE is ignored; it is not queued.

Test Plan:
- Reset, then pairs (3,4) and (5,6,last) with 18-cycle End_mul latency -> exactly one res_valid; res_acc=42, res_count=2, res_ovf=0. Begin_mul is high for exactly 1 cycle per pair.
- ACC_W=16, SATURATE=1, pairs (255,255) and (255,255,last) -> res_acc=65535, res_ovf=1. With SATURATE=0 -> res_acc=64514, res_ovf=1.
- End_mul held high before and during START -> no capture until End_mul has gone low and high again. The captured product is the correct new product, not the stale one.
- End_mul never asserted -> timeout_err=1 after 64 WAIT cycles, state returns to IDLE, acc unchanged. A following pair (2,2,last) -> res_acc equals prior acc + 4.
- Accumulate (10,10), then clear_acc in IDLE together with acceptance of (1,1,last) -> res_acc=1, res_count=1.
- Reset asserted during WAIT -> next cycle busy=0, in_ready=1, all result outputs 0, no res_valid pulse.
